// File: rtl/interconnect_bank_arbiter_if.sv
// Request/grant bundle between the PE ports, the init port and the bank arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants.
interface interconnect_bank_arbiter_if #(
    parameter int N_PE               = 16,
    parameter int N_GLOBAL_MEM_BANKS = 16
);
    localparam int BW = (N_GLOBAL_MEM_BANKS > 1) ? $clog2(N_GLOBAL_MEM_BANKS) : 1;
    localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic [N_PE-1:0]                        ld_req;
    logic [N_PE-1:0][BW-1:0]                ld_mem_bank_id;
    logic [N_PE-1:0]                        st_req;
    logic                                   init_mem_vld;
    logic [BW-1:0]                          init_bank_id;
    logic [N_PE-1:0]                        ld_gnt;
    logic [N_PE-1:0]                        st_gnt;
    logic [N_GLOBAL_MEM_BANKS-1:0][PW-1:0]  granted_requester_id;
    logic [N_GLOBAL_MEM_BANKS-1:0]          grant_out_port_wise;
    logic                                   idle;

    modport master (
        output ld_req, ld_mem_bank_id, st_req, init_mem_vld, init_bank_id,
        input  ld_gnt, st_gnt, granted_requester_id, grant_out_port_wise, idle
    );

    modport slave (
        input  ld_req, ld_mem_bank_id, st_req, init_mem_vld, init_bank_id,
        output ld_gnt, st_gnt, granted_requester_id, grant_out_port_wise, idle
    );
endinterface

// File: rtl/interconnect_bank_arbiter.sv
// Per-bank arbiter for the global memory banks: init > store > round-robin loads.
// Also tracks loads in the bank read pipeline to report interconnect idle.
module interconnect_bank_arbiter #(
    parameter int N_PE               = 16,
    parameter int N_GLOBAL_MEM_BANKS = 16,
    parameter int RD_LATENCY         = 2
) (
    input logic                         clk,
    input logic                         rst,
    interconnect_bank_arbiter_if.slave  bus
);
    localparam int NB = N_GLOBAL_MEM_BANKS;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1;

    // The top stage is the cycle the bank hands back data, so it no longer
    // counts as outstanding: idle rises RD_LATENCY cycles after the grant.
    localparam logic [RD_LATENCY-1:0] INFLIGHT_MASK =
        ~(RD_LATENCY'(1) << (RD_LATENCY - 1));

    logic [NB-1:0][PW-1:0]   r_rr_ptr;
    logic [RD_LATENCY-1:0]   r_inflight;

    logic [N_PE-1:0]         w_ld_gnt;
    logic [N_PE-1:0]         w_st_gnt;
    logic [NB-1:0][PW-1:0]   w_gid;
    logic [NB-1:0]           w_gop;
    logic [NB-1:0]           w_ld_hit;
    logic [NB-1:0][PW-1:0]   w_win;
    logic                    w_no_req;
    int                      w_idx;

    always_comb begin
        w_ld_gnt = '0;
        w_st_gnt = '0;
        w_gid    = '0;
        w_gop    = '0;
        w_ld_hit = '0;
        w_win    = '0;
        w_idx    = 0;
        for (int b = 0; b < NB; b++) begin
            if (bus.init_mem_vld && bus.init_bank_id == BW'(b)) begin
                w_gop[b] = 1'b0;
            end else if (bus.st_req[b]) begin
                w_st_gnt[b] = 1'b1;
                w_gop[b]    = 1'b1;
            end else begin
                for (int k = 0; k < N_PE; k++) begin
                    w_idx = int'(r_rr_ptr[b]) + k;
                    if (w_idx >= N_PE)
                        w_idx = w_idx - N_PE;
                    if (!w_ld_hit[b] && bus.ld_req[w_idx] &&
                        bus.ld_mem_bank_id[w_idx] == BW'(b)) begin
                        w_ld_hit[b] = 1'b1;
                        w_win[b]    = PW'(w_idx);
                    end
                end
                if (w_ld_hit[b]) begin
                    w_ld_gnt[w_win[b]] = 1'b1;
                    w_gid[b]           = w_win[b];
                    w_gop[b]           = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_inflight <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_ld_hit[b])
                    r_rr_ptr[b] <= (w_win[b] == PW'(N_PE - 1)) ?
                                   '0 : w_win[b] + PW'(1);
            end
            r_inflight[0] <= |w_ld_gnt;
            for (int i = 1; i < RD_LATENCY; i++)
                r_inflight[i] <= r_inflight[i-1];
        end
    end

    assign w_no_req = ~|bus.ld_req && ~|bus.st_req && !bus.init_mem_vld;

    assign bus.ld_gnt               = rst ? w_ld_gnt : '0;
    assign bus.st_gnt               = rst ? w_st_gnt : '0;
    assign bus.granted_requester_id = rst ? w_gid    : '0;
    assign bus.grant_out_port_wise  = rst ? w_gop    : '0;
    assign bus.idle = !rst ||
                      (w_no_req && (r_inflight & INFLIGHT_MASK) == '0);
endmodule

// File: tb/tb_interconnect_bank_arbiter.sv
// Directed bench for interconnect_bank_arbiter with 4 PEs, 4 banks, latency 2.
module tb_interconnect_bank_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    interconnect_bank_arbiter_if #(.N_PE(4), .N_GLOBAL_MEM_BANKS(4)) bus ();

    interconnect_bank_arbiter #(
        .N_PE(4), .N_GLOBAL_MEM_BANKS(4), .RD_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ld_req         = '0;
        bus.ld_mem_bank_id = '0;
        bus.st_req         = '0;
        bus.init_mem_vld   = 1'b0;
        bus.init_bank_id   = '0;
    endtask

    initial begin
        clear_inputs();
        #2;
        chk("reset_idle", 32'(bus.idle), 32'h1);
        chk("reset_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Round-robin on bank 2, including pointer wrap
        bus.ld_req = 4'b1111;
        for (int p = 0; p < 4; p++) bus.ld_mem_bank_id[p] = 2'd2;
        #1;
        chk("rr_c0_gnt", 32'(bus.ld_gnt), 32'b0001);
        chk("rr_c0_gid", 32'(bus.granted_requester_id), 32'h00);
        chk("rr_c0_gop", 32'(bus.grant_out_port_wise), 32'b0100);
        tick(); #1;
        chk("rr_c1_gnt", 32'(bus.ld_gnt), 32'b0010);
        chk("rr_c1_gid", 32'(bus.granted_requester_id), 32'h10);
        tick(); #1;
        chk("rr_c2_gnt", 32'(bus.ld_gnt), 32'b0100);
        chk("rr_c2_gid", 32'(bus.granted_requester_id), 32'h20);
        tick(); #1;
        chk("rr_c3_gnt", 32'(bus.ld_gnt), 32'b1000);
        chk("rr_c3_gid", 32'(bus.granted_requester_id), 32'h30);
        tick(); #1;
        chk("rr_wrap_gnt", 32'(bus.ld_gnt), 32'b0001);
        tick(); #1;
        chk("rr_c5_gnt", 32'(bus.ld_gnt), 32'b0010);

        // Reset in the middle of the round-robin traffic
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_gnt", 32'(bus.ld_gnt), 32'h0);
        chk("rst_mid_gid", 32'(bus.granted_requester_id), 32'h0);
        chk("rst_mid_gop", 32'(bus.grant_out_port_wise), 32'h0);
        chk("rst_mid_idle", 32'(bus.idle), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_after_gnt", 32'(bus.ld_gnt), 32'b0001);

        tick();
        clear_inputs();
        tick(); tick(); tick();
        #1;
        chk("quiet_idle", 32'(bus.idle), 32'h1);

        // Store beats a load on bank 1
        bus.ld_req = 4'b0001;
        bus.ld_mem_bank_id[0] = 2'd1;
        bus.st_req = 4'b0010;
        #1;
        chk("st_gnt", 32'(bus.st_gnt), 32'b0010);
        chk("st_ld_gnt", 32'(bus.ld_gnt), 32'b0000);
        chk("st_gop", 32'(bus.grant_out_port_wise), 32'b0010);
        tick();
        bus.st_req = '0;
        #1;
        chk("st_next_ld_gnt", 32'(bus.ld_gnt), 32'b0001);
        chk("st_next_gop", 32'(bus.grant_out_port_wise), 32'b0010);

        // Init owns bank 3; parallel load on bank 0 still granted
        tick();
        clear_inputs();
        bus.init_mem_vld = 1'b1;
        bus.init_bank_id = 2'd3;
        bus.st_req = 4'b1000;
        bus.ld_req = 4'b0110;
        bus.ld_mem_bank_id[1] = 2'd3;
        bus.ld_mem_bank_id[2] = 2'd0;
        #1;
        chk("init_st_gnt", 32'(bus.st_gnt), 32'b0000);
        chk("init_ld_gnt", 32'(bus.ld_gnt), 32'b0100);
        chk("init_gop", 32'(bus.grant_out_port_wise), 32'b0001);
        chk("init_gid", 32'(bus.granted_requester_id), 32'h02);
        tick();
        bus.init_mem_vld = 1'b0;
        bus.ld_req = 4'b0000;
        #1;
        chk("init_retry_st", 32'(bus.st_gnt), 32'b1000);

        // All four banks in parallel
        tick();
        clear_inputs();
        bus.ld_req = 4'b1111;
        bus.ld_mem_bank_id[0] = 2'd3;
        bus.ld_mem_bank_id[1] = 2'd2;
        bus.ld_mem_bank_id[2] = 2'd1;
        bus.ld_mem_bank_id[3] = 2'd0;
        #1;
        chk("par_gnt", 32'(bus.ld_gnt), 32'b1111);
        chk("par_gid", 32'(bus.granted_requester_id), 32'h1B);
        chk("par_gop", 32'(bus.grant_out_port_wise), 32'b1111);

        // Idle after a single load
        tick();
        clear_inputs();
        tick(); tick(); tick();
        bus.ld_req = 4'b0001;
        #1;
        chk("idle_c0_gnt", 32'(bus.ld_gnt), 32'b0001);
        chk("idle_c0", 32'(bus.idle), 32'h0);
        tick();
        bus.ld_req = '0;
        #1;
        chk("idle_c1", 32'(bus.idle), 32'h0);
        tick(); #1;
        chk("idle_c2", 32'(bus.idle), 32'h1);
        tick(); #1;
        chk("idle_c3", 32'(bus.idle), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
